// File: rtl/fc_param_loader.sv
// fc_param_loader: streams fixed-point parameter words into the four FC
// parameter RAMs (L1 bias, L1 weights, L2 bias, L2 weights) in ascending
// address order, one word per cycle at full throughput.
module fc_param_loader #(
   parameter int DATA_W = 16,
   parameter int L1_IN  = 120,
   parameter int L1_OUT = 84,
   parameter int L2_OUT = 10,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [1:0]        wr_sel,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LEN_L1B = L1_OUT;
   localparam int unsigned LEN_L1W = L1_IN * L1_OUT;
   localparam int unsigned LEN_L2B = L2_OUT;
   localparam int unsigned LEN_L2W = L1_OUT * L2_OUT;

   typedef enum logic [2:0] {
      IDLE,
      L1_BIAS,
      L1_W,
      L2_BIAS,
      L2_W,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] seg_last;
   logic [1:0]        seg_sel;
   logic              accept;

   // Per-segment last address and target RAM select, decoded from the state
   always_comb begin
      seg_last = '0;
      seg_sel  = 2'd0;
      case (state)
         L1_BIAS: begin seg_last = ADDR_W'(LEN_L1B - 1); seg_sel = 2'd0; end
         L1_W:    begin seg_last = ADDR_W'(LEN_L1W - 1); seg_sel = 2'd1; end
         L2_BIAS: begin seg_last = ADDR_W'(LEN_L2B - 1); seg_sel = 2'd2; end
         L2_W:    begin seg_last = ADDR_W'(LEN_L2W - 1); seg_sel = 2'd3; end
         default: begin seg_last = '0;                   seg_sel = 2'd0; end
      endcase
   end

   assign in_ready = (state inside {L1_BIAS, L1_W, L2_BIAS, L2_W});
   assign accept   = in_valid && in_ready;
   // The final write lands in the first DONE cycle, so stay busy until it is out
   assign busy     = in_ready || ((state == DONE) && wr_en);

   // Load sequencer: segment walk, address counter and registered write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         wr_en   <= 1'b0;
         wr_sel  <= 2'd0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
      end else begin
         wr_en <= accept;
         done  <= (state == DONE) && !start;
         if (accept) begin
            wr_sel  <= seg_sel;
            wr_addr <= cnt;
            wr_data <= in_data;
            if (cnt == seg_last) begin
               cnt <= '0;
               case (state)
                  L1_BIAS: state <= L1_W;
                  L1_W:    state <= L2_BIAS;
                  L2_BIAS: state <= L2_W;
                  default: state <= DONE;
               endcase
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if ((state == IDLE || state == DONE) && start) begin
            state <= L1_BIAS;
            cnt   <= '0;
         end
      end
   end

endmodule

// File: doc/fc_param_loader.md
# fc_param_loader

Streaming writer for the fully-connected layer parameter memories. Accepts 16-bit fixed-point words over a valid/ready stream and writes them, in a fixed order, into the four FC parameter RAMs: layer-1 bias, layer-1 weights, layer-2 bias and layer-2 weights. It replaces simulation-time file loading, so the same parameter set can be loaded at run time from a host or DMA. It sits between the parameter input stream and the FC block's memory write ports.

## Interface
- DATA_W, 16, parameter word width (fixed-point, binary).
- L1_IN, 120, layer-1 input count.
- L1_OUT, 84, layer-1 output count (layer-1 bias depth; layer-2 input count).
- L2_OUT, 10, layer-2 output count (layer-2 bias depth).
- ADDR_W, 14, write address width; must satisfy 2^ADDR_W >= L1_IN*L1_OUT.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader accepts a word this cycle.
- wr_en  out  1  memory write strobe.
- wr_sel  out  2  target RAM: 0 = L1 bias, 1 = L1 weights, 2 = L2 bias, 3 = L2 weights.
- wr_addr  out  ADDR_W  word address within the target RAM.
- wr_data  out  DATA_W  word to write.
- busy  out  1  high while a load is in progress.
- done  out  1  level; high once all words are written, until the next start or reset.

## Operation
- States: IDLE, L1_BIAS, L1_W, L2_BIAS, L2_W, DONE.
- Segment lengths: L1_BIAS = L1_OUT (84), L1_W = L1_IN*L1_OUT (10080), L2_BIAS = L2_OUT (10), L2_W = L1_OUT*L2_OUT (840). A full load is 11014 words.
- Word order within a segment is ascending address starting at 0. This order matches the file order of the offline parameter dumps.
- IDLE or DONE with start = 1: the next state is L1_BIAS, the counter is cleared and done is cleared.
- start is ignored while in a loading state. A running load is never restarted.
- in_ready = 1 exactly in the four loading states, and is combinational from the state.
- Handshake: a word is accepted when in_valid && in_ready. Without a handshake the counter and state hold.
- On accept:
  - The word is registered to wr_data with wr_sel = current segment, wr_addr = counter and wr_en = 1 on the next cycle.
  - The counter increments.
  - When the counter reaches segment length − 1, the counter clears to 0 and the state advances: L1_BIAS → L1_W → L2_BIAS → L2_W → DONE.
- The counter is ADDR_W bits wide and never exceeds segment length − 1. No wrap or overflow is possible.
- DONE: in_ready = 0, so extra stream words are back-pressured and never written. done = 1.
- busy = 1 in the loading states, or while the final write is still pending.
- rst asserted at any time, including mid-load:
  - State → IDLE, counter → 0.
  - The pending write is dropped.
  - Partially written RAM contents are left as-is; a new start overwrites everything.

## Timing
- Reset values: in_ready 0, wr_en 0, wr_sel 0, wr_addr 0, wr_data 0, busy 0, done 0.
- Write latency: exactly 1 cycle from handshake to wr_en. Full throughput is one word per cycle with no bubbles at segment boundaries.
- wr_en is high for exactly one cycle per accepted word. wr_sel, wr_addr and wr_data are held from the last write when wr_en = 0.
- The cycle after start: in_ready = 1 and busy = 1.
- The last word is accepted in cycle N. Then the state is DONE in cycle N+1 and wr_en for L2 weight 839 is also in cycle N+1. busy drops and done rises in cycle N+2.
- start in the same cycle as rst: rst wins.

## Test plan
- Full load, in_valid held high, data = running index 0..11013:
  - Expect 11014 writes, each with wr_data = index.
  - Write index 84 has wr_sel 1, addr 0; index 10164 has wr_sel 2, addr 0; index 10174 has wr_sel 3, addr 0; the last write has wr_sel 3, addr 839.
  - done rises 2 cycles after the final accept.
- Random in_valid gaps (50% duty): the same address/data sequence as the full-load case, with wr_en only on cycles following a handshake.
- Stream kept valid after DONE: in_ready stays 0, no further wr_en, done stays 1.
- start pulsed mid-load at L1_W addr 500: ignored. The load continues to addr 501, and the total write count is unchanged.
- rst asserted at L1_W addr 3000, then start: all outputs return to reset values immediately. The new load begins at wr_sel 0, addr 0.
- Back-to-back load: a second start in DONE clears done the next cycle and repeats the full sequence with identical addressing.
